// File: rtl/prng_word_packer.sv
// PRNG byte packer: repetition-count health test, word packing and output FIFO.
// A tripped health test halts sampling until clr_stuck is pulsed.
module prng_word_packer #(
    parameter int IN_BITS    = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [IN_BITS-1:0]            PRNG,
    input  logic                          clr_stuck,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IN_BITS*PACK-1:0]       out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          stuck,
    output logic [7:0]                    drop_cnt
);

    localparam int OUT_BITS = IN_BITS * PACK;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int LW       = PW + 1;
    localparam int CW       = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic {RUN, HALT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_rep_cnt;
    logic [IN_BITS-1:0]    r_prev;
    logic [OUT_BITS-1:0]   r_part;
    logic [CW-1:0]         r_cnt;
    logic                  r_stuck;
    logic [OUT_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr;
    logic [PW-1:0]         r_rd;
    logic [LW-1:0]         r_level;
    logic [7:0]            r_drop;

    logic                  w_sample;
    logic                  w_match;
    logic [7:0]            w_rep_nxt;
    logic                  w_trip;
    logic                  w_last;
    logic                  w_push;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;
    logic [OUT_BITS-1:0]   w_word;

    assign w_sample  = (r_state == RUN) && en;
    assign w_match   = (r_rep_cnt != 8'd0) && (PRNG == r_prev);
    assign w_rep_nxt = w_match ? r_rep_cnt + 8'd1 : 8'd1;
    assign w_trip    = w_sample && (w_rep_nxt == 8'(REP_LIMIT));
    assign w_last    = (r_cnt == CW'(PACK - 1));
    assign w_push    = w_sample && !w_trip && w_last;
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_pop     = (r_level != '0) && out_ready;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // Partial word with the current sample dropped into its slot
    always_comb begin
        w_word = r_part;
        w_word[r_cnt*IN_BITS +: IN_BITS] = PRNG;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:  if (w_trip)    w_state_nxt = HALT;
            HALT: if (clr_stuck) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
            r_prev    <= '0;
            r_part    <= '0;
            r_cnt     <= '0;
            r_stuck   <= 1'b0;
        end else if (r_state == HALT) begin
            if (clr_stuck) begin
                r_stuck   <= 1'b0;
                r_rep_cnt <= '0;
            end
        end else if (en) begin
            r_rep_cnt <= w_rep_nxt;
            r_prev    <= PRNG;
            if (w_trip) begin
                r_part  <= '0;
                r_cnt   <= '0;
                r_stuck <= 1'b1;
            end else if (w_last) begin
                r_part <= '0;
                r_cnt  <= '0;
            end else begin
                r_part <= w_word;
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_drop  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= w_word;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop) r_rd <= r_rd + PW'(1);
            if (w_wr && !w_pop)      r_level <= r_level + LW'(1);
            else if (!w_wr && w_pop) r_level <= r_level - LW'(1);
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_data   = r_mem[r_rd];
    assign fifo_level = r_level;
    assign stuck      = r_stuck;
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_prng_word_packer.sv
// Randomized bench for prng_word_packer with a queue-based reference model
// plus directed scenarios holding literal expectations.
module tb_prng_word_packer;

    localparam int REP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  PRNG = 8'h00;
    logic        clr_stuck = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  fifo_level;
    logic        stuck;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    prng_word_packer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .PRNG(PRNG),
        .clr_stuck(clr_stuck), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .stuck(stuck), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: byte list for the partial word, word queue for the FIFO
    logic [7:0]  m_part[$];
    logic [31:0] m_q[$];
    logic [7:0]  m_prev = 8'h00;
    int          m_rep = 0;
    bit          m_stuck = 0;
    int          m_drop = 0;
    bit          m_pop, m_push;
    int          m_nr;
    logic [31:0] m_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_part.delete();
            m_q.delete();
            m_prev = 8'h00;
            m_rep = 0;
            m_stuck = 0;
            m_drop = 0;
        end else begin
            m_pop = (m_q.size() > 0) && out_ready;
            m_push = 0;
            m_w = 32'h0;
            if (m_stuck) begin
                if (clr_stuck) begin
                    m_stuck = 0;
                    m_rep = 0;
                end
            end else if (en) begin
                m_nr = (m_rep != 0 && PRNG == m_prev) ? m_rep + 1 : 1;
                m_prev = PRNG;
                m_rep = m_nr;
                if (m_nr == REP) begin
                    m_stuck = 1;
                    m_part.delete();
                end else begin
                    m_part.push_back(PRNG);
                    if (m_part.size() == 4) begin
                        for (int k = 0; k < 4; k++)
                            m_w = m_w | (32'(m_part[k]) << (8 * k));
                        m_part.delete();
                        m_push = 1;
                    end
                end
            end
            if (m_push && m_q.size() == 4 && !m_pop) begin
                if (m_drop < 255) m_drop++;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) m_q.push_back(m_w);
            end
        end
    end

    logic [31:0] log_q[$];

    always @(negedge clk) begin
        checks++;
        if (out_valid !== (m_q.size() != 0)) begin
            failures++;
            $display("FAIL out_valid: got %b want %b at %0t", out_valid, m_q.size() != 0, $time);
        end
        checks++;
        if (fifo_level !== 3'(m_q.size())) begin
            failures++;
            $display("FAIL fifo_level: got %0d want %0d at %0t", fifo_level, m_q.size(), $time);
        end
        checks++;
        if (stuck !== m_stuck) begin
            failures++;
            $display("FAIL stuck: got %b want %b at %0t", stuck, m_stuck, $time);
        end
        checks++;
        if (drop_cnt !== 8'(m_drop)) begin
            failures++;
            $display("FAIL drop_cnt: got %0d want %0d at %0t", drop_cnt, m_drop, $time);
        end
        if (m_q.size() != 0) begin
            checks++;
            if (out_data !== m_q[0]) begin
                failures++;
                $display("FAIL out_data: got %h want %h at %0t", out_data, m_q[0], $time);
            end
        end
        if (rst_n && out_valid && out_ready) log_q.push_back(out_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [7:0] p, input logic r, input logic c);
        en = e;
        PRNG = p;
        out_ready = r;
        clr_stuck = c;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] last_p;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_level", 32'(fifo_level), 32'h0);
        chk("reset_data", out_data, 32'h0);

        // Basic pack
        drive(1, 8'h01, 1, 0);
        drive(1, 8'h02, 1, 0);
        drive(1, 8'h03, 1, 0);
        drive(1, 8'h04, 1, 0);
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_data", out_data, 32'h04030201);
        drive(0, 8'h00, 1, 0);
        chk("basic_valid_once", 32'(out_valid), 32'h0);
        chk("basic_level", 32'(fifo_level), 32'h0);

        // Gapped enable
        log_q.delete();
        drive(1, 8'h01, 1, 0);
        drive(1, 8'h02, 1, 0);
        repeat (3) begin
            drive(0, 8'h55, 1, 0);
            chk("gap_level", 32'(fifo_level), 32'h0);
        end
        drive(1, 8'h03, 1, 0);
        drive(1, 8'h04, 1, 0);
        chk("gap_data", out_data, 32'h04030201);
        drive(0, 8'h00, 1, 0);
        chk("gap_count", log_q.size(), 32'd1);

        // Overflow
        for (int i = 0; i < 20; i++) drive(1, 8'(8'h20 + i), 0, 0);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_drop", 32'(drop_cnt), 32'd1);
        chk("ovf_head", out_data, 32'h23222120);
        log_q.delete();
        repeat (6) drive(0, 8'h00, 1, 0);
        chk("ovf_n", log_q.size(), 32'd4);
        if (log_q.size() == 4) begin
            chk("ovf_w0", log_q[0], 32'h23222120);
            chk("ovf_w1", log_q[1], 32'h27262524);
            chk("ovf_w2", log_q[2], 32'h2b2a2928);
            chk("ovf_w3", log_q[3], 32'h2f2e2d2c);
        end

        // Health test
        log_q.delete();
        for (int i = 0; i < 16; i++) drive(1, 8'hAA, 1, 0);
        chk("hlth_stuck", 32'(stuck), 32'h1);
        repeat (6) drive(1, 8'hAA, 1, 0);
        chk("hlth_n", log_q.size(), 32'd3);
        foreach (log_q[i]) chk("hlth_word", log_q[i], 32'hAAAAAAAA);
        drive(0, 8'h00, 1, 1);
        chk("hlth_clr", 32'(stuck), 32'h0);
        log_q.delete();
        for (int i = 0; i < 4; i++) drive(1, 8'(8'h10 + i), 1, 0);
        drive(0, 8'h00, 1, 0);
        chk("hlth_resume_n", log_q.size(), 32'd1);
        if (log_q.size() == 1) chk("hlth_resume", log_q[0], 32'h13121110);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 19; i++) drive(1, 8'(8'h60 + i), 0, 0);
        chk("pp_full", 32'(fifo_level), 32'd4);
        drive(1, 8'h73, 1, 0);
        chk("pp_level", 32'(fifo_level), 32'd4);
        chk("pp_drop", 32'(drop_cnt), 32'd1);

        // Async reset with queued words and a partial word
        repeat (6) drive(0, 8'h00, 1, 0);
        for (int i = 0; i < 11; i++) drive(1, 8'(8'h40 + i), 0, 0);
        chk("ar_pre", 32'(fifo_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_level", 32'(fifo_level), 32'h0);
        chk("ar_drop", 32'(drop_cnt), 32'h0);
        chk("ar_stuck", 32'(stuck), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1, 8'(8'h50 + i), 0, 0);
        chk("ar_post_level", 32'(fifo_level), 32'd1);
        chk("ar_post_data", out_data, 32'h53525150);
        drive(0, 8'h00, 1, 0);

        // Random phase
        last_p = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) >= 85) last_p = 8'($urandom);
            drive($urandom_range(0, 9) < 7, last_p,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
